// File: rtl/pipe_pkg.sv
// Shared definitions for the EX/MEM pipeline stage: control bit positions,
// default widths and the slot payload layout.
package pipe_pkg;

    localparam int CTRL_MEM_TO_REG = 0;
    localparam int CTRL_REG_WRITE  = 1;
    localparam int CTRL_MEM_WRITE  = 2;
    localparam int CTRL_MEM_READ   = 3;

    localparam int DEF_CTRL_W = 4;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_W  = 5;

    // ctrl sits in the low bits so a slot can clear it without knowing the rest
    typedef struct packed {
        logic [DEF_DATA_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
        logic [DEF_REG_W-1:0]  rd;
        logic [DEF_CTRL_W-1:0] ctrl;
    } slot_t;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: valid bit plus payload, with load, clear and sync active-low reset.
// Clear drops the valid bit and zeroes the low CLR_W payload bits (the control field).
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int W     = $bits(slot_t),
    parameter int CLR_W = DEF_CTRL_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid              <= 1'b0;
            r_data[CLR_W-1:0]    <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/exe_mem_skid.sv
// EX/MEM stage with valid/ready handshake, one-entry skid buffer and synchronous flush.
// in_ready is a register, so out_ready never reaches in_ready combinationally.
module exe_mem_skid
    import pipe_pkg::*;
#(
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_alu_res,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [REG_W-1:0]  in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_wdata,
    output logic [REG_W-1:0]  out_rd
);

    localparam int PW = 2*DATA_W + REG_W + CTRL_W;

    logic          r_in_ready;
    logic [PW-1:0] w_in_pay, w_main_pay, w_skid_pay, w_main_d;
    logic          w_main_vld, w_skid_vld;
    logic          w_accept, w_consume;
    logic          w_main_load, w_main_clear, w_skid_load, w_skid_clear, w_skid_vld_nxt;
    logic [CTRL_W-1:0] w_main_ctrl;

    assign w_in_pay  = {in_alu_res, in_wdata, in_rd, in_ctrl};
    assign w_accept  = in_valid && r_in_ready && !flush;
    assign w_consume = w_main_vld && out_ready;

    // Skid always refills main first so FIFO order is kept; r_in_ready is 0 whenever skid is full.
    assign w_main_load  = !flush && ((w_skid_vld && w_consume) ||
                                     (w_accept && (!w_main_vld || w_consume)));
    assign w_main_clear = flush || (w_consume && !w_main_load);
    assign w_main_d     = w_skid_vld ? w_skid_pay : w_in_pay;

    assign w_skid_load    = !flush && w_accept && w_main_vld && !w_consume;
    assign w_skid_clear   = flush || (w_consume && w_skid_vld);
    assign w_skid_vld_nxt = !flush && (w_skid_load || (w_skid_vld && !w_consume));

    pipe_slot #(.W(PW), .CLR_W(CTRL_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_data  (w_main_d),
        .o_valid (w_main_vld),
        .o_data  (w_main_pay)
    );

    pipe_slot #(.W(PW), .CLR_W(CTRL_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (w_in_pay),
        .o_valid (w_skid_vld),
        .o_data  (w_skid_pay)
    );

    always_ff @(posedge clk) begin
        if (!rst) r_in_ready <= 1'b0;
        else      r_in_ready <= !w_skid_vld_nxt;
    end

    assign {out_addr, out_wdata, out_rd, w_main_ctrl} = w_main_pay;
    assign out_valid = w_main_vld;
    assign out_ctrl  = w_main_vld ? w_main_ctrl : '0;
    assign in_ready  = r_in_ready;

endmodule
